// File: rtl/mips_pkg.sv
// Shared opcode, ALU-op and mux-select encodings plus the control FSM state type
// and the packed control word produced by the state decoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    // pcwrite is the unconditional request; pc_cond asks for a zero-qualified write.
    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       pc_cond;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Pure combinational decode of the FSM state into the raw control word;
// input-dependent qualification (mem_ready, zero, wait timeout) is applied by the caller.
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  state_t state_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.irwrite = 1'b1;
                ctrl_o.pcwrite = 1'b1;
                ctrl_o.pcsrc   = PCSRC_ALU;
                ctrl_o.alusrcb = SRCB_FOUR;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            S_DECODE: begin
                ctrl_o.alusrcb = SRCB_IMMSH;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.memtoreg = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_req  = 1'b1;
                ctrl_o.memwrite = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_REGB;
                ctrl_o.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.regdst   = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_REGB;
                ctrl_o.aluop   = ALUOP_SUB;
                ctrl_o.pcsrc   = PCSRC_ALUOUT;
                ctrl_o.pc_cond = 1'b1;
            end
            S_ADDIWB: begin
                ctrl_o.regwrite = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pcsrc   = PCSRC_JUMP;
                ctrl_o.pcwrite = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM: sequences each instruction, bounds memory waits,
// keeps sticky illegal/bus-error flags and a retired-instruction counter.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             alu_err,
    input  logic             mem_ready,
    input  logic             zero,
    output logic             mem_req,
    output logic             memwrite,
    output logic             iord,
    output logic             irwrite,
    output logic             pcwrite,
    output logic [1:0]       pcsrc,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               illegal_q, illegal_d;
    logic               bus_err_q, bus_err_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               retire;
    logic               timeout;
    logic               fetch;
    ctrl_t              cw;
    ctrl_t              cw_g;

    mips_ctrl_decode u_decode (
        .state_i (state_q),
        .ctrl_o  (cw)
    );

    // Once the budget is spent the request is withdrawn for one cycle; a late
    // mem_ready in that cycle still completes the access.
    assign timeout = (wait_q == WAIT_W'(WAIT_MAX));
    assign fetch   = (state_q == S_FETCH);

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        wait_d    = '0;
        retire    = 1'b0;

        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC: begin
                if (alu_err) begin
                    state_d   = S_FETCH;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_ALUWB;
                end
            end
            S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase

        if (cw.mem_req && !mem_ready) begin
            if (timeout) begin
                state_d   = S_FETCH;
                bus_err_d = 1'b1;
            end else begin
                wait_d = wait_q + WAIT_W'(1);
            end
        end

        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        cw_g = reset ? '0 : cw;

        mem_req  = cw_g.mem_req  & ~timeout;
        memwrite = cw_g.memwrite & ~timeout;
        iord     = cw_g.iord;
        irwrite  = cw_g.irwrite & mem_ready;
        pcwrite  = fetch ? (cw_g.pcwrite & mem_ready)
                         : (cw_g.pcwrite | (cw_g.pc_cond & zero));
        pcsrc    = cw_g.pcsrc;
        alusrca  = cw_g.alusrca;
        alusrcb  = cw_g.alusrcb;
        aluop    = cw_g.aluop;
        regdst   = cw_g.regdst;
        memtoreg = cw_g.memtoreg;
        regwrite = cw_g.regwrite;

        illegal  = illegal_q & ~reset;
        bus_err  = bus_err_q & ~reset;
        retired  = reset ? '0 : retired_q;
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multi-cycle control FSM: per-cycle control-word tables
// for each instruction class, reset abort, sticky flags and memory-wait timeout.
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] T_BAD   = 6'b111111;

    // {mem_req,memwrite,iord,irwrite,pcwrite}_{pcsrc}_{alusrca}_{alusrcb}_{aluop}_{regdst,memtoreg,regwrite}
    localparam logic [14:0] C_ZERO    = 15'b00000_00_0_00_00_000;
    localparam logic [14:0] C_FETCH_R = 15'b10011_00_0_01_00_000;
    localparam logic [14:0] C_FETCH_W = 15'b10000_00_0_01_00_000;
    localparam logic [14:0] C_FETCH_T = 15'b00000_00_0_01_00_000;
    localparam logic [14:0] C_FETCH_L = 15'b00011_00_0_01_00_000;
    localparam logic [14:0] C_DECODE  = 15'b00000_00_0_11_00_000;
    localparam logic [14:0] C_MEMADR  = 15'b00000_00_1_10_00_000;
    localparam logic [14:0] C_MEMRD   = 15'b10100_00_0_00_00_000;
    localparam logic [14:0] C_MEMWB   = 15'b00000_00_0_00_00_011;
    localparam logic [14:0] C_MEMWR   = 15'b11100_00_0_00_00_000;
    localparam logic [14:0] C_EXEC    = 15'b00000_00_1_00_10_000;
    localparam logic [14:0] C_ALUWB   = 15'b00000_00_0_00_00_101;
    localparam logic [14:0] C_BR_T    = 15'b00001_01_1_00_01_000;
    localparam logic [14:0] C_BR_N    = 15'b00000_01_1_00_01_000;
    localparam logic [14:0] C_ADDIWB  = 15'b00000_00_0_00_00_001;
    localparam logic [14:0] C_JUMP    = 15'b00001_10_0_00_00_000;

    logic        clk = 1'b0;
    logic        reset, alu_err, mem_ready, zero;
    logic [5:0]  opcode;
    logic        mem_req, memwrite, iord, irwrite, pcwrite, alusrca;
    logic        regdst, memtoreg, regwrite, illegal, bus_err;
    logic [1:0]  pcsrc, alusrcb, aluop;
    logic [31:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    mips_multicycle_ctrl #(.CNT_W(32), .WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .alu_err(alu_err),
        .mem_ready(mem_ready), .zero(zero), .mem_req(mem_req), .memwrite(memwrite),
        .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite), .pcsrc(pcsrc),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .illegal(illegal),
        .bus_err(bus_err), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] obs();
        return {mem_req, memwrite, iord, irwrite, pcwrite, pcsrc, alusrca,
                alusrcb, aluop, regdst, memtoreg, regwrite};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1; mem_ready = 1'b0; alu_err = 1'b0; zero = 1'b0; opcode = '0;
        repeat (n) next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b0; alu_err = 1'b0; zero = 1'b0; opcode = '0;
        repeat (2) next_cycle();
        n_tests++;
        if (obs() !== C_ZERO || retired !== 32'd0 || illegal !== 1'b0 || bus_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: ctrl=%b retired=%0d illegal=%b bus_err=%b want all zero",
                     obs(), retired, illegal, bus_err);
        end
        reset = 1'b0;
    endtask

    task automatic test_rtype();
        logic [14:0] exp [4];
        logic [31:0] r0;
        exp = '{C_FETCH_R, C_DECODE, C_EXEC, C_ALUWB};
        r0 = retired;
        for (int i = 0; i < 4; i++) begin
            opcode = T_RTYPE; mem_ready = (i == 0); zero = 1'b0; alu_err = 1'b0;
            #1;
            n_tests++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL rtype cyc%0d: ctrl=%b want %b", i, obs(), exp[i]);
            end
            next_cycle();
        end
        n_tests++;
        if (retired !== r0 + 32'd1) begin
            n_fail++;
            $display("FAIL rtype_retired: got %0d want %0d", retired, r0 + 32'd1);
        end
    endtask

    task automatic test_lw_wait();
        logic [14:0] exp [7];
        logic [6:0]  rdy;
        logic [31:0] r0;
        exp = '{C_FETCH_R, C_DECODE, C_MEMADR, C_MEMRD, C_MEMRD, C_MEMRD, C_MEMWB};
        rdy = 7'b010_0001;
        r0 = retired;
        for (int i = 0; i < 7; i++) begin
            opcode = T_LW; mem_ready = rdy[i];
            #1;
            n_tests++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL lw cyc%0d: ctrl=%b want %b", i, obs(), exp[i]);
            end
            next_cycle();
        end
        n_tests++;
        if (retired !== r0 + 32'd1) begin
            n_fail++;
            $display("FAIL lw_retired: got %0d want %0d", retired, r0 + 32'd1);
        end
    endtask

    task automatic test_beq();
        logic [14:0] exp [6];
        logic [31:0] r0;
        exp = '{C_FETCH_R, C_DECODE, C_BR_T, C_FETCH_R, C_DECODE, C_BR_N};
        r0 = retired;
        for (int i = 0; i < 6; i++) begin
            opcode = T_BEQ; mem_ready = (i == 0 || i == 3); zero = (i == 2);
            #1;
            n_tests++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL beq cyc%0d: ctrl=%b want %b", i, obs(), exp[i]);
            end
            next_cycle();
        end
        zero = 1'b0;
        n_tests++;
        if (retired !== r0 + 32'd2) begin
            n_fail++;
            $display("FAIL beq_retired: got %0d want %0d", retired, r0 + 32'd2);
        end
    endtask

    // sw, addi and j back to back with mem_ready held high throughout.
    task automatic test_back_to_back();
        logic [14:0] exp [11];
        logic [31:0] r0;
        exp = '{C_FETCH_R, C_DECODE, C_MEMADR, C_MEMWR,
                C_FETCH_R, C_DECODE, C_MEMADR, C_ADDIWB,
                C_FETCH_R, C_DECODE, C_JUMP};
        r0 = retired;
        for (int i = 0; i < 11; i++) begin
            opcode = (i < 4) ? T_SW : (i < 8) ? T_ADDI : T_J;
            mem_ready = 1'b1;
            #1;
            n_tests++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL b2b cyc%0d: ctrl=%b want %b", i, obs(), exp[i]);
            end
            next_cycle();
        end
        n_tests++;
        if (retired !== r0 + 32'd3) begin
            n_fail++;
            $display("FAIL b2b_retired: got %0d want %0d", retired, r0 + 32'd3);
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] exp [4];
        exp = '{C_FETCH_R, C_DECODE, C_MEMADR, C_MEMRD};
        for (int i = 0; i < 4; i++) begin
            opcode = T_LW; mem_ready = (i == 0);
            #1;
            n_tests++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL rstmid_pre cyc%0d: ctrl=%b want %b", i, obs(), exp[i]);
            end
            next_cycle();
        end
        reset = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (obs() !== C_ZERO) begin
                n_fail++;
                $display("FAIL rstmid_hold cyc%0d: ctrl=%b want %b", i, obs(), C_ZERO);
            end
            next_cycle();
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (obs() !== C_FETCH_W || retired !== 32'd0) begin
            n_fail++;
            $display("FAIL rstmid_after: ctrl=%b retired=%0d want %b retired=0",
                     obs(), retired, C_FETCH_W);
        end
        next_cycle();
    endtask

    task automatic test_illegal_opcode();
        logic [14:0] exp [3];
        exp = '{C_FETCH_R, C_DECODE, C_FETCH_W};
        for (int i = 0; i < 3; i++) begin
            opcode = T_BAD; mem_ready = (i == 0);
            #1;
            n_tests++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL illop cyc%0d: ctrl=%b want %b", i, obs(), exp[i]);
            end
            next_cycle();
        end
        n_tests++;
        if (illegal !== 1'b1 || retired !== 32'd0) begin
            n_fail++;
            $display("FAIL illop_flags: illegal=%b retired=%0d want 1 and 0", illegal, retired);
        end
    endtask

    task automatic test_alu_err();
        logic [14:0] exp [4];
        exp = '{C_FETCH_R, C_DECODE, C_EXEC, C_FETCH_W};
        n_tests++;
        if (illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL aluerr_clear: illegal=%b want 0", illegal);
        end
        for (int i = 0; i < 4; i++) begin
            opcode = T_RTYPE; mem_ready = (i == 0); alu_err = (i == 2);
            #1;
            n_tests++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL aluerr cyc%0d: ctrl=%b want %b", i, obs(), exp[i]);
            end
            next_cycle();
        end
        alu_err = 1'b0;
        n_tests++;
        if (illegal !== 1'b1 || retired !== 32'd0) begin
            n_fail++;
            $display("FAIL aluerr_flags: illegal=%b retired=%0d want 1 and 0", illegal, retired);
        end
    endtask

    // mem_ready arrives in the cycle the wait budget runs out: the fetch completes.
    task automatic test_access_wins();
        logic [14:0] e;
        for (int i = 0; i < 18; i++) begin
            opcode = T_J; mem_ready = (i == 15);
            e = (i < 15) ? C_FETCH_W : (i == 15) ? C_FETCH_L : (i == 16) ? C_DECODE : C_JUMP;
            #1;
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL latewin cyc%0d: ctrl=%b want %b", i, obs(), e);
            end
            next_cycle();
        end
        n_tests++;
        if (bus_err !== 1'b0 || retired !== 32'd1) begin
            n_fail++;
            $display("FAIL latewin_flags: bus_err=%b retired=%0d want 0 and 1", bus_err, retired);
        end
    endtask

    task automatic test_bus_err();
        logic [14:0] e;
        for (int i = 0; i < 17; i++) begin
            opcode = T_RTYPE; mem_ready = 1'b0;
            e = (i == 15) ? C_FETCH_T : C_FETCH_W;
            #1;
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL buserr cyc%0d: ctrl=%b want %b", i, obs(), e);
            end
            if (i == 15) begin
                n_tests++;
                if (bus_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL buserr_early: bus_err=%b want 0", bus_err);
                end
            end
            next_cycle();
        end
        n_tests++;
        if (bus_err !== 1'b1 || retired !== 32'd1) begin
            n_fail++;
            $display("FAIL buserr_flags: bus_err=%b retired=%0d want 1 and 1", bus_err, retired);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_back_to_back();
        n_tests++;
        if (retired !== 32'd7) begin
            n_fail++;
            $display("FAIL retired_total: got %0d want 7", retired);
        end
        test_reset_mid();
        test_illegal_opcode();
        apply_reset(2);
        test_alu_err();
        apply_reset(2);
        test_access_wins();
        test_bus_err();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
